// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op encodings, FSM states and sizing shared by mul_div_unit
package mul_div_unit_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = MD_WIDTH;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_e;
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply / restoring divide owning HI and LO
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int data_width = MD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [data_width-1:0] src_a,
  input  logic [data_width-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] hi_reg,
  output logic [data_width-1:0] lo_reg
);
  localparam int dw = data_width;
  localparam int cw = $clog2(MD_ITERS * dw / MD_WIDTH);
  md_state_e state, state_n;
  logic [cw-1:0] cnt;
  logic [dw-1:0] m, a_abs, b_abs, div_rem;
  logic [2*dw-1:0] acc, acc_next, prod_fix;
  logic [dw:0] mul_sum;
  logic sgn, is_div, neg_q, neg_r, dz, div_borrow, accept;
  assign sgn = !op[0] && !op[2];
  assign a_abs = (sgn && src_a[dw-1]) ? -src_a : src_a;
  assign b_abs = (sgn && src_b[dw-1]) ? -src_b : src_b;
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign mul_sum = {1'b0, acc[2*dw-1:dw]} + (acc[0] ? {1'b0, m} : '0);
  assign div_borrow = acc[2*dw-1:dw-1] < {1'b0, m};
  assign div_rem = acc[2*dw-2:dw-1] - m;
  assign prod_fix = neg_q ? -acc : acc;
  always_comb begin
    acc_next = is_div ? (div_borrow ? {acc[2*dw-2:0], 1'b0} : {div_rem, acc[dw-2:0], 1'b1})
                      : {mul_sum, acc[dw-1:1]};
    state_n = state == IDLE ? ((start && !op[2]) ? CALC : IDLE)
            : state == CALC ? ((cnt == cw'(dw - 1)) ? FIX : CALC)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (accept && !op[2]) begin
      is_div <= op[1];
      m      <= op[1] ? b_abs : a_abs;
      acc    <= {{dw{1'b0}}, op[1] ? a_abs : b_abs};
      neg_q  <= sgn && (src_a[dw-1] ^ src_b[dw-1]);
      neg_r  <= sgn && src_a[dw-1];
      dz     <= src_b == '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
      done   <= 1'b0;
    end else begin
      done <= state == FIX;
      if (accept && op == MD_MTHI) hi_reg <= src_a;
      if (accept && op == MD_MTLO) lo_reg <= src_a;
      if (state == FIX) begin
        hi_reg <= is_div ? (neg_r ? -acc[2*dw-1:dw] : acc[2*dw-1:dw]) : prod_fix[2*dw-1:dw];
        lo_reg <= is_div ? (dz ? '1 : neg_q ? -acc[dw-1:0] : acc[dw-1:0]) : prod_fix[dw-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with directed vectors
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic busy, done;
  logic [31:0] hi_reg, lo_reg;
  int vectors = 0, miscompares = 0, busy_run = 0, done_seen = 0, issued = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi_reg(hi_reg), .lo_reg(lo_reg)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) busy_run = 0;
    else begin
      if (busy) busy_run++;
      if (done) begin
        done_seen++;
        check("busy_cycles", 64'(busy_run), 64'd33);
        check("busy_low_at_done", {63'd0, busy}, 64'd0);
        busy_run = 0;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, {32'd0, hi_reg}, {32'd0, e.hi});
          check({e.name, "_lo"}, {32'd0, lo_reg}, {32'd0, e.lo});
        end
      end
    end
  end
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input string name,
                     input int poke);
    logic got;
    got = 1'b0;
    sb.push_back('{eh, el, name});
    issued++;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      start = (i == poke);
      if (i == poke) begin
        op = MD_DIVU; src_a = 32'd100; src_b = 32'd3;
      end
      @(negedge clk);
      got = done;
    end
    start = 1'b0;
    check({name, "_completed"}, {63'd0, got}, 64'd1);
    if (!got) sb.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset_hi", {32'd0, hi_reg}, 64'd0);
    check("reset_lo", {32'd0, lo_reg}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", -1);
    run(MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7_busy_start", 9);
    run(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2", -1);
    run(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2", -1);
    run(MD_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, "divu_by_zero", -1);
    run(MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div_signed_by_zero", -1);
    run(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow", -1);
    run(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq", -1);
    run(MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_max_16", -1);
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; src_a = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", {32'd0, hi_reg}, 64'h12345678);
    check("mthi_busy_done", {62'd0, busy, done}, 64'd0);
    op = MD_MTLO; src_a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", {32'd0, lo_reg}, 64'h9ABCDEF0);
    check("mtlo_hi_held", {32'd0, hi_reg}, 64'h12345678);
    check("mtlo_busy_done", {62'd0, busy, done}, 64'd0);
    start = 1'b1; op = 3'd6; src_a = 32'hDEADBEEF; src_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("op6_ignored", {hi_reg, lo_reg}, 64'h12345678_9ABCDEF0);
    check("op6_no_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b1; op = MD_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("div_inflight_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_hilo", {hi_reg, lo_reg}, 64'd0);
    check("abort_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_stays_idle", {62'd0, busy, done}, 64'd0);
    run(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7_after_reset", -1);
    repeat (3) @(negedge clk);
    check("done_pulse_count", 64'(done_seen), 64'(issued));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit that owns the architectural HI and LO registers of the MIPS core. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage and computes products and quotients over 33 cycles with a shared shift-add / shift-subtract datapath. Drives `busy` so the hazard logic stalls issue. Its `hi_reg`/`lo_reg` outputs feed the write-back mux for MFHI/MFLO.

## Interface
- `data_width`, 32: operand and HI/LO width; iteration count equals `data_width`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request valid this cycle; sampled only while idle.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- `src_a`  in  data_width  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `src_b`  in  data_width  rt operand: multiplier or divisor.
- `busy`  out  1  high while a MULT/DIV is in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a MULT/DIV result.
- `hi_reg`  out  data_width  architectural HI.
- `lo_reg`  out  data_width  architectural LO.

## Operation
- Reset values: `hi_reg`=0, `lo_reg`=0, `busy`=0, `done`=0; FSM in IDLE.
- FSM states: IDLE, CALC, FIX.
- IDLE with `start`=1:
  - op 4: HI←`src_a` at that edge; stay IDLE; no `done`.
  - op 5: LO←`src_a` at that edge; stay IDLE; no `done`.
  - op 0–3: latch operands; go to CALC; iteration counter = 0.
  - op 6–7: ignore.
- Signed ops (0, 2):
  - Latch absolute values of both operands.
  - Record sign flags: result sign = sign(a) XOR sign(b); remainder sign = sign(a).
- CALC: one radix-2 step per cycle; after step `data_width` go to FIX.
  - Multiply: 2·data_width accumulator, shift-add.
  - Divide: restoring shift-subtract.
- FIX:
  - Apply two's-complement correction per the sign flags.
  - Multiply: HI←upper half, LO←lower half.
  - Divide: LO←quotient, HI←remainder.
  - Pulse `done`; return to IDLE.
- Divide by zero (either signedness): LO=all ones, HI=`src_a` as given, with no sign correction; completes with the normal latency.
- Signed overflow −2^(w−1) ÷ −1: LO=0x80000000, HI=0.
- `start` while `busy`: ignored. Upstream must stall; no queuing.
- `op`, `src_a` and `src_b` are don't-care outside the accepting IDLE cycle.
- `rst` mid-operation: abort; all outputs return to reset values on that edge.

## Timing
- `start` with op 0–3 sampled at edge k:
  - `busy` rises after edge k and falls after edge k+33, so it is high for 33 cycles.
  - `hi_reg`/`lo_reg` update at edge k+33.
  - `done` is high for the single cycle following edge k+33.
- A new `start` is accepted at edge k+33 at the earliest: `busy` is already 0 in the cycle where `done`=1.
- MTHI/MTLO: result visible the cycle after the accepting edge; `busy` never asserts.
- HI/LO outputs hold between updates; no intermediate values are ever visible on them.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - op encodings (`MD_MULT`…`MD_MTLO`)
  - FSM state enum (IDLE/CALC/FIX)
  - iteration count constant derived from `data_width`.
- Single module; the datapath is one 2·data_width shift register shared by multiply and divide.
- No sub-module is needed. Sign fix-up stays inline in FIX.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, `done` pulse once.
- MULT −3 × 7 (0xFFFFFFFD, 0x7) → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 ÷ 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU 100 ÷ 0 → LO=0xFFFFFFFF, HI=100, normal latency.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles:
  - HI and LO update one cycle after each accept.
  - `busy`/`done` stay 0.
  - A `start` with DIVU issued at cycle 10 of a busy MULT leaves the MULT result intact.
- Assert `rst` at cycle 15 of a DIV → next cycle HI=LO=0, `busy`=0, no `done`; a fresh MULTU 6×7 afterwards yields LO=42, HI=0.
